fft32_tw_sequencer: RTL and testbench

Control sequencer for the in-place 32-point radix-2 DIF FFT engine. It drives the 5-bit twiddle ROM address and the butterfly operand indices through 5 stages of 16 butterflies each. It also inserts inter-stage gaps so each stage sees the previous stage's writes. A delayed copy of the indices and valid is provided, aligned with the registered twiddle ROM output.

---
 rtl/fft32_tw_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_fft32_tw_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft32_tw_sequencer.sv
// rtl/fft32_tw_sequencer.sv - issue sequencer for an in-place 32-point radix-2 DIF FFT
//
// Walks 5 stages x 16 butterflies. For each butterfly it presents the operand
// indices and the twiddle ROM address. Idle gap cycles are inserted between
// stages. A TW_LAT-deep copy of valid/indices lines up with the twiddle ROM data.
//
// Parameters:
//   TW_LAT    twiddle ROM latency in cycles (0..3)
//   STAGE_GAP idle cycles between consecutive stages (0..7)
//
// Ports:
//   clk      in   master clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a transform (sampled only when idle)
//   hold     in   suppress butterfly issue this cycle
//   inv      in   inverse transform select (used only with FFT_TW_SEQ_INV_EN)
//   busy     out  transform in progress, through the done cycle
//   done     out  one-cycle pulse with the last wr_valid
//   stage    out  current stage 0..4
//   bf_valid out  idx_a/idx_b/tw_addr valid this cycle
//   idx_a    out  upper operand index
//   idx_b    out  lower operand index
//   tw_addr  out  twiddle ROM address
//   wr_valid out  bf_valid delayed TW_LAT cycles
//   wr_a     out  idx_a delayed TW_LAT cycles
//   wr_b     out  idx_b delayed TW_LAT cycles
//
// Optional feature macro: FFT_TW_SEQ_INV_EN (conjugate twiddle addressing when inv=1).

module fft32_tw_sequencer #(
    parameter int TW_LAT    = 1,
    parameter int STAGE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic [2:0] stage,
    output logic       bf_valid,
    output logic [4:0] idx_a,
    output logic [4:0] idx_b,
    output logic [4:0] tw_addr,
    output logic       wr_valid,
    output logic [4:0] wr_a,
    output logic [4:0] wr_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] GAP_LAST   = 3'(STAGE_GAP > 0 ? STAGE_GAP - 1 : 0);
    localparam logic [1:0] DRAIN_LAST = 2'(TW_LAT > 0 ? TW_LAT - 1 : 0);

    state_t     state, state_n;
    logic [2:0] s, s_n;
    logic [3:0] b, b_n;
    logic [2:0] gcnt, gcnt_n;
    logic [1:0] dcnt, dcnt_n;
    logic       issue;
    logic       done_c;

    // Operand / twiddle arithmetic for the butterfly (s, b)
    logic [4:0] span, pos, base, calc_a, calc_b, tw_fwd, calc_tw;
    logic [4:0] last_a, last_b, last_tw;

`ifdef FFT_TW_SEQ_INV_EN
    logic inv_r;

    // inv is captured when the transform is accepted and held for its duration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r <= 1'b0;
        end else if (state == IDLE && start) begin
            inv_r <= inv;
        end
    end
`else
    logic inv_unused;
    assign inv_unused = inv;
`endif

    always_comb begin
        span   = 5'd16 >> s;
        pos    = {1'b0, b} & (span - 5'd1);
        // grp*2*span == (b - pos)*2, since grp*span == b - pos
        base   = ({1'b0, b} - pos) << 1;
        calc_a = base + pos;
        calc_b = calc_a + span;
        tw_fwd = pos << s;
        calc_tw = tw_fwd;
`ifdef FFT_TW_SEQ_INV_EN
        // Conjugate twiddle: W^(32-k); k=0 wraps back to 0
        if (inv_r) begin
            calc_tw = 5'd0 - tw_fwd;
        end
`endif
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        b_n     = b;
        gcnt_n  = gcnt;
        dcnt_n  = dcnt;
        issue   = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    s_n     = 3'd0;
                    b_n     = 4'd0;
                end
            end
            RUN: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (b == 4'd15) begin
                        if (s == 3'd4) begin
                            if (TW_LAT == 0) begin
                                // Last issue is already the last write
                                done_c  = 1'b1;
                                state_n = IDLE;
                            end else begin
                                state_n = DRAIN;
                                dcnt_n  = 2'd0;
                            end
                        end else if (STAGE_GAP > 0) begin
                            state_n = GAP;
                            gcnt_n  = 3'd0;
                        end else begin
                            s_n = s + 3'd1;
                            b_n = 4'd0;
                        end
                    end else begin
                        b_n = b + 4'd1;
                    end
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_n = RUN;
                    s_n     = s + 3'd1;
                    b_n     = 4'd0;
                end else begin
                    gcnt_n = gcnt + 3'd1;
                end
            end
            DRAIN: begin
                if (dcnt == DRAIN_LAST) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end else begin
                    dcnt_n = dcnt + 2'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= 3'd0;
            b       <= 4'd0;
            gcnt    <= 3'd0;
            dcnt    <= 2'd0;
            last_a  <= 5'd0;
            last_b  <= 5'd0;
            last_tw <= 5'd0;
        end else begin
            state <= state_n;
            s     <= s_n;
            b     <= b_n;
            gcnt  <= gcnt_n;
            dcnt  <= dcnt_n;
            if (issue) begin
                last_a  <= calc_a;
                last_b  <= calc_b;
                last_tw <= calc_tw;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_c;
    assign stage    = s;
    assign bf_valid = issue;
    // Issue outputs show the live butterfly, otherwise keep the last issued one
    assign idx_a    = issue ? calc_a  : last_a;
    assign idx_b    = issue ? calc_b  : last_b;
    assign tw_addr  = issue ? calc_tw : last_tw;

    // Alignment pipeline; free-running like the ROM register, so hold bubbles
    // pass through as wr_valid=0
    generate
        if (TW_LAT == 0) begin : g_no_lat
            assign wr_valid = bf_valid;
            assign wr_a     = idx_a;
            assign wr_b     = idx_b;
        end else begin : g_lat
            logic [TW_LAT-1:0]      v_pipe;
            logic [TW_LAT-1:0][4:0] a_pipe;
            logic [TW_LAT-1:0][4:0] b_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_pipe <= '0;
                    a_pipe <= '0;
                    b_pipe <= '0;
                end else begin
                    v_pipe[0] <= bf_valid;
                    a_pipe[0] <= idx_a;
                    b_pipe[0] <= idx_b;
                    for (int i = 1; i < TW_LAT; i++) begin
                        v_pipe[i] <= v_pipe[i-1];
                        a_pipe[i] <= a_pipe[i-1];
                        b_pipe[i] <= b_pipe[i-1];
                    end
                end
            end

            assign wr_valid = v_pipe[TW_LAT-1];
            assign wr_a     = a_pipe[TW_LAT-1];
            assign wr_b     = b_pipe[TW_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_fft32_tw_sequencer.sv
// tb/tb_fft32_tw_sequencer.sv - self-checking bench for fft32_tw_sequencer (TW_LAT=1, STAGE_GAP=2)

module tb_fft32_tw_sequencer;

`ifdef FFT_TW_SEQ_INV_EN
    localparam bit INV_BUILT = 1'b1;
`else
    localparam bit INV_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       inv = 1'b0;
    logic       busy, done, bf_valid, wr_valid;
    logic [2:0] stage;
    logic [4:0] idx_a, idx_b, tw_addr, wr_a, wr_b;

    fft32_tw_sequencer #(.TW_LAT(1), .STAGE_GAP(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hold     (hold),
        .inv      (inv),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .bf_valid (bf_valid),
        .idx_a    (idx_a),
        .idx_b    (idx_b),
        .tw_addr  (tw_addr),
        .wr_valid (wr_valid),
        .wr_a     (wr_a),
        .wr_b     (wr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int b;
        int a;
        int bb;
        int tw;
    } vec_t;

    vec_t vt[13];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int n_iss, n_wr, done_cnt, done_cyc, busy_cnt, busy_first, busy_last, hold_idx;
    int iss_a[80], iss_b[80], iss_tw[80], iss_st[80], iss_cyc[80];
    int wr_a_l[80], wr_b_l[80], wr_cyc[80];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_tw(input int fwd, input bit inv_v);
        if (INV_BUILT && inv_v) return (32 - fwd) & 31;
        return fwd;
    endfunction

    function automatic int all_outs();
        return int'({busy, done, stage, bf_valid, idx_a, idx_b, tw_addr, wr_valid, wr_a, wr_b});
    endfunction

    task automatic clear_log();
        n_iss = 0; n_wr = 0; done_cnt = 0; done_cyc = 0;
        busy_cnt = 0; busy_first = 0; busy_last = 0; hold_idx = -1;
        iss_cyc[0] = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle_end();
        @(negedge clk);
        if (bf_valid) begin
            if (n_iss < 80) begin
                iss_a[n_iss] = int'(idx_a);
                iss_b[n_iss] = int'(idx_b);
                iss_tw[n_iss] = int'(tw_addr);
                iss_st[n_iss] = int'(stage);
                iss_cyc[n_iss] = cyc;
            end
            n_iss++;
        end
        if (wr_valid) begin
            if (n_wr < 80) begin
                wr_a_l[n_wr] = int'(wr_a);
                wr_b_l[n_wr] = int'(wr_b);
                wr_cyc[n_wr] = cyc;
            end
            n_wr++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) begin
            if (busy_cnt == 0) busy_first = cyc;
            busy_cnt++;
            busy_last = cyc;
        end
        if (hold && busy && !bf_valid) hold_idx = int'(idx_a);
    endtask

    task automatic run_xfer(input int hold_iss, input int hold_len, input int extra_start_iss,
                            input bit start_at_done, input logic inv_v);
        int  hc;
        bit  sent;
        hc = 0;
        sent = 1'b0;
        clear_log();
        next_cycle(); start = 1'b1; inv = inv_v; hold = 1'b0; cycle_end();
        next_cycle(); start = 1'b0; inv = 1'b0; cycle_end();
        for (int t = 0; t < 200; t++) begin
            next_cycle();
            hold = (n_iss == hold_iss && hc < hold_len);
            if (hold) hc++;
            start = (extra_start_iss >= 0 && n_iss == extra_start_iss && !sent);
            if (start) sent = 1'b1;
            if (start_at_done && n_iss > 0 && cyc == iss_cyc[0] + 88) start = 1'b1;
            cycle_end();
            if (done_cnt > 0 && cyc >= done_cyc + 6) break;
        end
        next_cycle();
        hold = 1'b0;
        start = 1'b0;
        cycle_end();
    endtask

    function automatic int timing_errs(input int hold_at, input int hold_len);
        int e;
        int exp;
        e = 0;
        for (int i = 0; i < 80; i++) begin
            exp = iss_cyc[0] + i + 2 * (i / 16) + ((i >= hold_at) ? hold_len : 0);
            if (iss_cyc[i] != exp) e++;
        end
        return e;
    endfunction

    function automatic int wr_errs();
        int e;
        e = 0;
        for (int i = 0; i < 80; i++) begin
            if (wr_a_l[i] != iss_a[i] || wr_b_l[i] != iss_b[i] || wr_cyc[i] != iss_cyc[i] + 1) e++;
        end
        return e;
    endfunction

    initial begin
        bit got;
        int k;

        // stage, b, idx_a, idx_b, forward tw_addr
        vt[0]  = '{0, 0, 0, 16, 0};
        vt[1]  = '{0, 1, 1, 17, 1};
        vt[2]  = '{0, 5, 5, 21, 5};
        vt[3]  = '{0, 15, 15, 31, 15};
        vt[4]  = '{1, 0, 0, 8, 0};
        vt[5]  = '{1, 3, 3, 11, 6};
        vt[6]  = '{1, 12, 20, 28, 8};
        vt[7]  = '{2, 5, 9, 13, 4};
        vt[8]  = '{3, 6, 12, 14, 0};
        vt[9]  = '{3, 7, 13, 15, 8};
        vt[10] = '{4, 5, 10, 11, 0};
        vt[11] = '{4, 15, 30, 31, 0};
        vt[12] = '{2, 15, 27, 31, 12};

        clear_log();

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            start = 1'($urandom_range(0, 1));
            hold  = 1'($urandom_range(0, 1));
            inv   = 1'($urandom_range(0, 1));
            cycle_end();
            chk("reset_outputs_zero", all_outs(), 0);
        end
        next_cycle(); rst_n = 1'b1; start = 1'b0; hold = 1'b0; inv = 1'b0; cycle_end();
        chk("post_reset_idle", all_outs(), 0);
        next_cycle(); start = 1'b1; cycle_end();
        chk("start_cycle_not_busy", int'(busy), 0);
        next_cycle(); start = 1'b0; cycle_end();
        chk("first_bf_valid", int'(bf_valid), 1);
        chk("first_busy", int'(busy), 1);
        chk("first_idx_a", int'(idx_a), 0);
        chk("first_idx_b", int'(idx_b), 16);
        chk("first_tw_addr", int'(tw_addr), 0);
        got = 1'b0;
        for (int t = 0; t < 150 && !got; t++) begin
            next_cycle(); cycle_end();
            if (!busy) got = 1'b1;
        end
        chk("first_xfer_ends", int'(got), 1);

        // Full run, inv=1 (forward addresses unless the inverse build is selected)
        run_xfer(-1, 0, -1, 1'b0, 1'b1);
        chk("A_issue_count", n_iss, 80);
        for (int i = 0; i < 13; i++) begin
            k = vt[i].s * 16 + vt[i].b;
            chk($sformatf("A_vec%0d_idx_a", i), iss_a[k], vt[i].a);
            chk($sformatf("A_vec%0d_idx_b", i), iss_b[k], vt[i].bb);
            chk($sformatf("A_vec%0d_tw", i), iss_tw[k], exp_tw(vt[i].tw, 1'b1));
            chk($sformatf("A_vec%0d_stage", i), iss_st[k], vt[i].s);
        end
        chk("A_issue_timing_errs", timing_errs(80, 0), 0);
        chk("A_wr_count", n_wr, 80);
        chk("A_wr_align_errs", wr_errs(), 0);
        chk("A_done_count", done_cnt, 1);
        chk("A_done_offset", done_cyc - iss_cyc[0], 88);
        chk("A_done_with_last_wr", done_cyc, wr_cyc[79]);
        chk("A_busy_len", busy_cnt, 89);
        chk("A_busy_first", busy_first, iss_cyc[0]);
        chk("A_busy_last", busy_last, done_cyc);

        // Hold for 3 cycles at stage 1, b=7
        run_xfer(23, 3, -1, 1'b0, 1'b0);
        chk("B_issue_count", n_iss, 80);
        chk("B_iss23_idx_a", iss_a[23], 7);
        chk("B_iss23_idx_b", iss_b[23], 15);
        chk("B_iss23_tw", iss_tw[23], 14);
        chk("B_held_idx_a", hold_idx, 6);
        chk("B_issue_gap", iss_cyc[23] - iss_cyc[22], 4);
        chk("B_wr_bubbles", wr_cyc[23] - wr_cyc[22], 4);
        chk("B_issue_timing_errs", timing_errs(23, 3), 0);
        chk("B_wr_align_errs", wr_errs(), 0);
        chk("B_done_count", done_cnt, 1);
        chk("B_done_offset", done_cyc - iss_cyc[0], 91);
        chk("B_busy_len", busy_cnt, 92);

        // start while busy (stage 3) and in the done cycle
        run_xfer(-1, 0, 50, 1'b1, 1'b0);
        chk("C_issue_count", n_iss, 80);
        chk("C_issue_timing_errs", timing_errs(80, 0), 0);
        chk("C_done_count", done_cnt, 1);
        chk("C_done_offset", done_cyc - iss_cyc[0], 88);
        chk("C_busy_len", busy_cnt, 89);
        chk("C_idle_after", int'(busy), 0);

        // Asynchronous reset at stage 2, b=9
        clear_log();
        next_cycle(); start = 1'b1; cycle_end();
        next_cycle(); start = 1'b0; cycle_end();
        got = 1'b0;
        for (int t = 0; t < 120 && !got; t++) begin
            next_cycle();
            if (n_iss == 41 && bf_valid) begin
                chk("D_stage_before_reset", int'(stage), 2);
                #2;
                rst_n = 1'b0;
                #1;
                chk("D_async_outputs_zero", all_outs(), 0);
                got = 1'b1;
            end
            cycle_end();
        end
        chk("D_reset_reached", int'(got), 1);
        next_cycle(); rst_n = 1'b1; cycle_end();
        for (int t = 0; t < 8; t++) begin
            next_cycle(); cycle_end();
        end
        chk("D_no_done", done_cnt, 0);
        chk("D_no_issue_after", n_iss, 41);
        chk("D_idle", int'(busy), 0);

        run_xfer(-1, 0, -1, 1'b0, 1'b0);
        chk("E_issue_count", n_iss, 80);
        chk("E_first_idx_b", iss_b[0], 16);
        chk("E_done_count", done_cnt, 1);
        chk("E_done_offset", done_cyc - iss_cyc[0], 88);
        chk("E_wr_align_errs", wr_errs(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
